// File: rtl/md_if.sv
// Issue/result bundle between the core's HI/LO issue logic and the multiply/divide unit.
// Handshake: an op is accepted on a rising edge where start=1 and busy=0; otherwise start is ignored.
interface md_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  state;

    modport master (output start, op, rs, rt, input busy, done, hi, lo, state);
    modport slave  (input start, op, rs, rt, output busy, done, hi, lo, state);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO: fixed-latency multiply,
// 32-step restoring divide on magnitudes, and single-edge mthi/mtlo.
module md_unit #(
    parameter int MULT_CYCLES = 5
) (
    input logic clk,
    input logic reset,
    md_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

    localparam logic [4:0] MUL_LAST = 5'(MULT_CYCLES - 1);
    localparam logic [4:0] DIV_LAST = 5'd31;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rs_q, rs_d;
    logic [31:0] rt_q, rt_d;
    logic        sgn_q, sgn_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        sgn_in;
    logic [31:0] a_mag, b_mag;
    logic [33:0] trial;
    logic        ge;
    logic [32:0] rem_nx;
    logic [31:0] quot_nx;
    logic [31:0] q_fix, r_fix;
    logic [63:0] prod;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        sgn_d   = sgn_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        // Odd opcodes (multu/divu) are the unsigned variants.
        sgn_in = ~bus.op[0];
        a_mag  = (sgn_in && bus.rs[31]) ? -bus.rs : bus.rs;
        b_mag  = (sgn_in && bus.rt[31]) ? -bus.rt : bus.rt;

        trial   = {rem_q, quot_q[31]};
        ge      = (trial >= {2'b00, dvs_q});
        rem_nx  = trial[32:0] - (ge ? {1'b0, dvs_q} : 33'd0);
        quot_nx = {quot_q[30:0], ge};
        q_fix   = (sgn_q && (rs_q[31] ^ rt_q[31])) ? -quot_nx : quot_nx;
        r_fix   = (sgn_q && rs_q[31]) ? -rem_nx[31:0] : rem_nx[31:0];

        prod = sgn_q ? ({{32{rs_q[31]}}, rs_q} * {{32{rt_q[31]}}, rt_q})
                     : ({32'd0, rs_q} * {32'd0, rt_q});

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    unique case (bus.op)
                        3'b000, 3'b001: begin
                            rs_d    = bus.rs;
                            rt_d    = bus.rt;
                            sgn_d   = sgn_in;
                            cnt_d   = 5'd0;
                            state_d = MUL;
                        end
                        3'b010, 3'b011: begin
                            rs_d    = bus.rs;
                            rt_d    = bus.rt;
                            sgn_d   = sgn_in;
                            cnt_d   = 5'd0;
                            rem_d   = 33'd0;
                            quot_d  = a_mag;
                            dvs_d   = b_mag;
                            state_d = DIV;
                        end
                        3'b100:  hi_d = bus.rs;
                        3'b101:  lo_d = bus.rs;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (cnt_q == MUL_LAST) begin
                    {hi_d, lo_d} = prod;
                    done_d       = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DIV: begin
                rem_d  = rem_nx;
                quot_d = quot_nx;
                if (cnt_q == DIV_LAST) begin
                    // Divide by zero bypasses the sign fix-up: lo all ones, hi the dividend.
                    if (rt_q == 32'd0) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = rs_q;
                    end else begin
                        lo_d = q_fix;
                        hi_d = r_fix;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            rs_q    <= 32'd0;
            rt_q    <= 32'd0;
            sgn_q   <= 1'b0;
            rem_q   <= 33'd0;
            quot_q  <= 32'd0;
            dvs_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            sgn_q   <= sgn_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases, back-to-back issue, mid-op reset,
// and random ops checked against an arithmetic reference model via a result queue.
module tb_md_unit;
  localparam int MC = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  md_if bus ();
  md_unit #(.MULT_CYCLES(MC)) dut (.clk(clk), .reset(reset), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Entry: {due edge index, hi, lo}
  logic [95:0] exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin q = sa * sb; return q; end
      3'd1: begin uq = ua * ub; return uq; end
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding result, on its due edge.
  always @(negedge clk) begin
    logic [95:0] e;
    if (reset && bus.done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("result", {bus.hi, bus.lo}, e[63:0]);
        chk("latency", 64'(cyc), 64'(e[95:64]));
      end
    end
  end

  task automatic wait_not_busy();
    int t;
    t = 0;
    @(negedge clk);
    while (bus.busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (bus.busy) chk("busy_timeout", 64'(bus.busy), 64'd0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int k);
    logic [63:0] e;
    int lat;
    wait_not_busy();
    bus.start = 1'b1;
    bus.op = op;
    bus.rs = a;
    bus.rt = b;
    @(posedge clk);
    #1;
    k = cyc;
    bus.start = 1'b0;
    bus.op = 3'($urandom_range(0, 7));
    bus.rs = $urandom;
    bus.rt = $urandom;
    if (op <= 3'd3) begin
      chk("busy_after_start", 64'(bus.busy), 64'd1);
      lat = (op <= 3'd1) ? MC : 32;
      e = model(op, a, b);
      exp_q.push_back({32'(k + lat), e});
      hi_m = e[63:32];
      lo_m = e[31:0];
    end else begin
      if (op == 3'd4) hi_m = a;
      if (op == 3'd5) lo_m = a;
      chk("idle_op_hilo", {bus.hi, bus.lo}, {hi_m, lo_m});
      chk("idle_op_busy", {62'd0, bus.busy, bus.done}, 64'd0);
    end
  endtask

  task automatic drain();
    wait_not_busy();
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  logic [2:0]  d_op [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd2};
  logic [31:0] d_a  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h1234, 32'h8000_0000};
  logic [31:0] d_b  [6] = '{32'd7, 32'd2, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
  logic [63:0] d_e  [6] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h0000_0001_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD,
                            64'h0000_0002_0000_000E, 64'h0000_1234_FFFF_FFFF, 64'h0000_0000_8000_0000};

  initial begin
    int k, t;
    logic [63:0] e;
    logic [2:0] op;
    logic [31:0] a, b;
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.rs = 32'd0;
    bus.rt = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed cases with spec-given expected values.
    for (int i = 0; i < 6; i++) begin
      issue(d_op[i], d_a[i], d_b[i], k);
      drain();
      chk($sformatf("directed_%0d", i), {bus.hi, bus.lo}, d_e[i]);
    end

    // mthi / mtlo while idle.
    issue(3'd4, 32'h55, 32'd0, k);
    chk("mthi_value", 64'(bus.hi), 64'h55);
    issue(3'd5, 32'h66, 32'd0, k);
    chk("mtlo_value", 64'(bus.lo), 64'h66);

    // Back-to-back: mult issued in the done cycle of a divu.
    issue(3'd3, 32'd1000, 32'd9, k);
    t = 0;
    @(negedge clk);
    while (!bus.done && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("b2b_done_seen", 64'(bus.done), 64'd1);
    bus.start = 1'b1;
    bus.op = 3'd0;
    bus.rs = 32'hFFFF_F000;
    bus.rt = 32'h0001_0003;
    @(posedge clk);
    #1;
    k = cyc;
    bus.start = 1'b0;
    e = model(3'd0, 32'hFFFF_F000, 32'h0001_0003);
    exp_q.push_back({32'(k + MC), e});
    for (int i = 0; i < MC; i++) begin
      chk("b2b_divu_held", {bus.hi, bus.lo}, {32'd1, 32'd111});
      @(posedge clk);
      #1;
    end
    chk("b2b_product", {bus.hi, bus.lo}, e);
    hi_m = e[63:32];
    lo_m = e[31:0];
    drain();

    // Mid-division mthi is ignored; asynchronous reset abandons the division.
    issue(3'd2, 32'h1234_5678, 32'h77, k);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.op = 3'd4;
    bus.rs = 32'hAAAA_AAAA;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_mthi_ignored", 64'(bus.hi), {32'd0, e[63:32]});
    while (cyc < k + 10) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("async_reset_busy", {62'd0, bus.busy, bus.done}, 64'd0);
    exp_q.delete();
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_hilo", {bus.hi, bus.lo}, 64'd0);

    // Random ops, sometimes back-to-back, against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      issue(op, a, b, k);
      if ($urandom_range(0, 1) == 0) drain();
    end
    drain();
    chk("final_hilo", {bus.hi, bus.lo}, {hi_m, lo_m});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
